uart_cmd_controller: RTL and testbench
======================================

UART_CMD_CONTROLLER -- requirements
Module: uart_cmd_controller

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning number of independent rom_en channels, legal 1..8.
REQ-002 SHALL have parameter REP, default 2, meaning number of identical command copies per frame, legal 2..4.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 50000, meaning maximum clock cycles allowed between bytes of one frame.
REQ-004 SHALL have port clock, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port uart_rx_ready, input, 1 bit: one-cycle strobe; uart_rx_data is valid on that cycle.
REQ-007 SHALL have port uart_rx_data, input, 8 bits: received byte.
REQ-008 SHALL have port uart_idle, input, 1 bit: transmitter can accept a byte.
REQ-009 SHALL have port uart_tx_sig, output, 1 bit: one-cycle transmit strobe.
REQ-010 SHALL have port uart_tx_data, output, 8 bits: response byte, stable from the PARSE edge until the next PARSE.
REQ-011 SHALL have port rom_en, output, NUM_CH bits: per-channel enable.
REQ-012 SHALL have port state_dbg, output, 4 bits: current state encoding, for LEDs.
REQ-013 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-014 SHALL implement the states IDLE, COLLECT, PARSE, WAIT_IDLE and SEND.
REQ-015 SHALL move IDLE->COLLECT on uart_rx_ready, storing the byte as the command and setting the copy count to 1.
REQ-016 SHALL, in COLLECT, on each uart_rx_ready, set a sticky mismatch flag if the byte differs from the command, and increment the copy count.
REQ-017 SHALL enter PARSE on the edge after the REP-th byte is accepted.
REQ-018 SHALL, in PARSE, when the mismatch flag is set, load uart_tx_data=0xEE and leave rom_en unchanged.
REQ-019 SHALL, in PARSE, decode the command and respond on uart_tx_data as follows:
- 0xF0 (ping) -> respond 0xF0.
- 0xA0+n with n<NUM_CH -> set rom_en[n]; respond with the command byte.
- 0xB0+n with n<NUM_CH -> clear rom_en[n]; respond with the command byte.
- 0xC0 -> clear all rom_en bits; respond 0xC0.
- 0xD0 -> respond with rom_en zero-extended to 8 bits.
- Any other value, including n>=NUM_CH -> respond 0xEF, no rom_en change.
REQ-020 SHALL always go PARSE->WAIT_IDLE after one cycle.
REQ-021 SHALL go WAIT_IDLE->SEND when uart_idle is high, and otherwise hold WAIT_IDLE indefinitely.
REQ-022 SHALL drive uart_tx_sig=1 for exactly the single SEND cycle, then go SEND->IDLE.
REQ-023 SHALL have fixed latency: last byte strobe at cycle T -> PARSE at T+1 -> WAIT_IDLE at T+2 -> uart_tx_sig high at T+3 if uart_idle is high at T+2.
REQ-024 SHALL silently drop uart_rx_ready strobes that arrive in PARSE, WAIT_IDLE or SEND; these bytes SHALL NOT start a frame.
REQ-025 SHALL treat a strobe on the same cycle as the SEND->IDLE transition as dropped.
REQ-026 SHALL change rom_en only on the PARSE edge.

Reset
REQ-027 SHALL, on reset low and regardless of clock, set state=IDLE, copy count=0, mismatch=0, command=0x00, uart_tx_data=0x00, uart_tx_sig=0, rom_en=0 and timer=0.
REQ-028 SHALL discard a frame or pending response in progress when reset is asserted mid-operation, and SHALL NOT emit a strobe after reset is released.

Configuration
REQ-029 SHALL, with UART_CMD_TIMEOUT_EN defined, do the following in COLLECT:
- Count cycles since the last accepted byte.
- On reaching TIMEOUT_CYC without a strobe, discard the partial frame.
- Load uart_tx_data=0xED and go to WAIT_IDLE.
- A strobe on the expiry cycle SHALL win: the byte is accepted and the counter restarts.
REQ-030 SHALL, without UART_CMD_TIMEOUT_EN, contain no timer logic and have COLLECT wait indefinitely.

Structure
REQ-031 SHALL import command codes (F0, A0, B0, C0, D0), response codes (EE, EF, ED) and the 4-bit state encoding from package uart_cmd_pkg.
REQ-032 SHALL place the inter-byte timer in sub-module uart_cmd_timer, with ports clock, reset, clear, run and expired, and counter width $clog2(TIMEOUT_CYC+1).

Verification
REQ-033 SHALL cover: bytes F0,F0 with uart_idle=1 -> uart_tx_data=0xF0, uart_tx_sig pulse 3 cycles after the second byte, rom_en unchanged.
REQ-034 SHALL cover: A2,A2 then D0,D0 -> rom_en=4'b0100 after the first frame; second response=0x04.
REQ-035 SHALL cover: A1,A7 -> response 0xEE and rom_en unchanged; with NUM_CH=4, A5,A5 -> response 0xEF.
REQ-036 SHALL cover: with REP=3, C0,C0,C0 while uart_idle=0 for 20 cycles -> rom_en=0, state held in WAIT_IDLE, a single strobe one cycle after uart_idle rises, and extra bytes injected meanwhile dropped.
REQ-037 SHALL cover: with UART_CMD_TIMEOUT_EN and TIMEOUT_CYC=100, a single byte B0 then silence -> response 0xED after 100 cycles; without the macro -> no response.
REQ-038 SHALL cover: reset asserted in WAIT_IDLE -> all outputs at reset values asynchronously and no uart_tx_sig after release.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared command/response codes, FSM state encoding and decode helper for the
// UART command controller.
package uart_cmd_pkg;

   // command codes (channel commands carry the channel number in the low nibble)
   localparam logic [7:0] CMD_PING     = 8'hF0;
   localparam logic [7:0] CMD_SET      = 8'hA0;
   localparam logic [7:0] CMD_CLR      = 8'hB0;
   localparam logic [7:0] CMD_CLR_ALL  = 8'hC0;
   localparam logic [7:0] CMD_READ     = 8'hD0;

   // response codes
   localparam logic [7:0] RSP_MISMATCH = 8'hEE;
   localparam logic [7:0] RSP_BAD      = 8'hEF;
   localparam logic [7:0] RSP_TIMEOUT  = 8'hED;

   // 4-bit state encoding, also driven on the LED debug port
   localparam logic [3:0] ST_IDLE      = 4'h0;
   localparam logic [3:0] ST_COLLECT   = 4'h1;
   localparam logic [3:0] ST_PARSE     = 4'h2;
   localparam logic [3:0] ST_WAIT_IDLE = 4'h3;
   localparam logic [3:0] ST_SEND      = 4'h4;

   // true when cmd is opcode nibble op addressing an existing channel
   function automatic logic is_ch_cmd(input logic [7:0] cmd, input logic [3:0] op,
                                      input int unsigned num_ch);
      return (cmd[7:4] == op) && (32'(cmd[3:0]) < num_ch);
   endfunction

endpackage

// File: rtl/uart_cmd_if.sv
// UART byte handshake between the UART core (master) and the command controller (slave).
interface uart_cmd_if;
   logic       uart_rx_ready;
   logic [7:0] uart_rx_data;
   logic       uart_idle;
   logic       uart_tx_sig;
   logic [7:0] uart_tx_data;

   modport master (output uart_rx_ready, uart_rx_data, uart_idle,
                   input  uart_tx_sig, uart_tx_data);
   modport slave  (input  uart_rx_ready, uart_rx_data, uart_idle,
                   output uart_tx_sig, uart_tx_data);
endinterface

// File: rtl/uart_cmd_timer.sv
// Inter-byte timeout counter: counts run cycles since the last clear and
// flags expiry once TIMEOUT_CYC cycles have elapsed.
module uart_cmd_timer #(
   parameter int unsigned TIMEOUT_CYC = 50000
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic run,
   output logic expired
);
   localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_inc;

   assign cnt_inc = cnt_q + CW'(1);

   // count while running, freeze once expired, restart on clear
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_q   <= '0;
         expired <= 1'b0;
      end else if (clear) begin
         cnt_q   <= '0;
         expired <= 1'b0;
      end else if (run && !expired) begin
         cnt_q   <= cnt_inc;
         expired <= (cnt_inc == CW'(TIMEOUT_CYC));
      end
   end
endmodule

// File: rtl/uart_cmd_controller.sv
// UART command controller: collects REP identical copies of a command byte,
// decodes it into per-channel rom_en updates and sends one response byte.
// Optional inter-byte timeout enabled by defining UART_CMD_TIMEOUT_EN.
module uart_cmd_controller
   import uart_cmd_pkg::*;
#(
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned REP         = 2,
   parameter int unsigned TIMEOUT_CYC = 50000
) (
   input  logic              clock,
   input  logic              reset,
   uart_cmd_if.slave         uif,
   output logic [NUM_CH-1:0] rom_en,
   output logic [3:0]        state_dbg,
   output logic              busy
);
   localparam int unsigned CNT_W = $clog2(REP + 1);

   // elaboration-time parameter range checks
   if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
      $error("NUM_CH must be 1..8");
   end
   if (REP < 2 || REP > 4) begin : g_bad_rep
      $error("REP must be 2..4");
   end
   if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYC must be at least 1");
   end

   logic [3:0]        state_q, state_nxt;
   logic [7:0]        cmd_q, cmd_nxt;
   logic [CNT_W-1:0]  cnt_q, cnt_nxt;
   logic              mis_q, mis_nxt;
   logic [7:0]        txd_q, txd_nxt;
   logic              sig_q, sig_nxt;
   logic [NUM_CH-1:0] rom_q, rom_nxt;
   logic [NUM_CH-1:0] ch_mask;
   logic              busy_q, busy_nxt;

`ifdef UART_CMD_TIMEOUT_EN
   logic tmr_run, tmr_clear, tmr_expired;

   // timer runs only while collecting and restarts on every accepted byte
   assign tmr_run   = (state_q == ST_COLLECT);
   assign tmr_clear = !tmr_run || uif.uart_rx_ready;

   uart_cmd_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
      .clock   (clock),
      .reset   (reset),
      .clear   (tmr_clear),
      .run     (tmr_run),
      .expired (tmr_expired)
   );
`endif

   // next-state, datapath and response decode
   always_comb begin
      state_nxt = state_q;
      cmd_nxt   = cmd_q;
      cnt_nxt   = cnt_q;
      mis_nxt   = mis_q;
      txd_nxt   = txd_q;
      sig_nxt   = 1'b0;
      rom_nxt   = rom_q;
      ch_mask   = NUM_CH'(1) << cmd_q[3:0];

      case (state_q)
         ST_IDLE: begin
            if (uif.uart_rx_ready) begin
               cmd_nxt   = uif.uart_rx_data;
               cnt_nxt   = CNT_W'(1);
               mis_nxt   = 1'b0;
               state_nxt = ST_COLLECT;
            end
         end
         ST_COLLECT: begin
            if (uif.uart_rx_ready) begin
               if (uif.uart_rx_data != cmd_q) mis_nxt = 1'b1;
               cnt_nxt = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(REP - 1)) state_nxt = ST_PARSE;
            end
`ifdef UART_CMD_TIMEOUT_EN
            else if (tmr_expired) begin
               cnt_nxt   = '0;
               mis_nxt   = 1'b0;
               txd_nxt   = RSP_TIMEOUT;
               state_nxt = ST_WAIT_IDLE;
            end
`endif
         end
         ST_PARSE: begin
            state_nxt = ST_WAIT_IDLE;
            cnt_nxt   = '0;
            mis_nxt   = 1'b0;
            if (mis_q) begin
               txd_nxt = RSP_MISMATCH;
            end else if (cmd_q == CMD_PING) begin
               txd_nxt = CMD_PING;
            end else if (cmd_q == CMD_CLR_ALL) begin
               rom_nxt = '0;
               txd_nxt = CMD_CLR_ALL;
            end else if (cmd_q == CMD_READ) begin
               txd_nxt = 8'(rom_q);
            end else if (is_ch_cmd(cmd_q, CMD_SET[7:4], NUM_CH)) begin
               rom_nxt = rom_q | ch_mask;
               txd_nxt = cmd_q;
            end else if (is_ch_cmd(cmd_q, CMD_CLR[7:4], NUM_CH)) begin
               rom_nxt = rom_q & ~ch_mask;
               txd_nxt = cmd_q;
            end else begin
               txd_nxt = RSP_BAD;
            end
         end
         ST_WAIT_IDLE: begin
            if (uif.uart_idle) begin
               sig_nxt   = 1'b1;
               state_nxt = ST_SEND;
            end
         end
         ST_SEND: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase

      busy_nxt = (state_nxt != ST_IDLE);
   end

   // state and datapath registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cmd_q   <= 8'h00;
         cnt_q   <= '0;
         mis_q   <= 1'b0;
         txd_q   <= 8'h00;
         sig_q   <= 1'b0;
         rom_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_nxt;
         cmd_q   <= cmd_nxt;
         cnt_q   <= cnt_nxt;
         mis_q   <= mis_nxt;
         txd_q   <= txd_nxt;
         sig_q   <= sig_nxt;
         rom_q   <= rom_nxt;
         busy_q  <= busy_nxt;
      end
   end

   assign uif.uart_tx_sig  = sig_q;
   assign uif.uart_tx_data = txd_q;
   assign rom_en           = rom_q;
   assign state_dbg        = state_q;
   assign busy             = busy_q;
endmodule

// File: tb/tb_uart_cmd_controller.sv
// Self-checking bench for uart_cmd_controller: two instances (REP=2 and REP=3),
// directed frames, randomized frames with stray bytes, timeout and reset cases.
module tb_uart_cmd_controller;
   import uart_cmd_pkg::*;

   localparam int unsigned NCH = 4;
   localparam int unsigned TO  = 100;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       drv_ready [2];
   logic [7:0] drv_data  [2];
   logic       drv_idle  [2];

   wire        obs_sig  [2];
   wire  [7:0] obs_txd  [2];
   wire  [3:0] obs_rom  [2];
   wire  [3:0] obs_st   [2];
   wire        obs_busy [2];

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] rom_m [2];

   always #5 clk = ~clk;

   uart_cmd_if u_if0 ();
   uart_cmd_if u_if1 ();

   assign u_if0.uart_rx_ready = drv_ready[0];
   assign u_if0.uart_rx_data  = drv_data[0];
   assign u_if0.uart_idle     = drv_idle[0];
   assign obs_sig[0]          = u_if0.uart_tx_sig;
   assign obs_txd[0]          = u_if0.uart_tx_data;
   assign u_if1.uart_rx_ready = drv_ready[1];
   assign u_if1.uart_rx_data  = drv_data[1];
   assign u_if1.uart_idle     = drv_idle[1];
   assign obs_sig[1]          = u_if1.uart_tx_sig;
   assign obs_txd[1]          = u_if1.uart_tx_data;

   uart_cmd_controller #(.NUM_CH(NCH), .REP(2), .TIMEOUT_CYC(TO)) u_dut0 (
      .clock(clk), .reset(rst_n), .uif(u_if0),
      .rom_en(obs_rom[0]), .state_dbg(obs_st[0]), .busy(obs_busy[0]));

   uart_cmd_controller #(.NUM_CH(NCH), .REP(3), .TIMEOUT_CYC(TO)) u_dut1 (
      .clock(clk), .reset(rst_n), .uif(u_if1),
      .rom_en(obs_rom[1]), .state_dbg(obs_st[1]), .busy(obs_busy[1]));

   function automatic int rep_of(input int k);
      return (k == 0) ? 2 : 3;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // reference: response and new enable set for one complete frame
   task automatic model_frame(input int k, input logic [7:0] b0, b1, b2, b3,
                              output logic [7:0] rsp);
      logic [7:0] b [4];
      logic [7:0] c;
      int         n;
      bit         same;
      b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
      same = 1'b1;
      for (int i = 1; i < rep_of(k); i++) if (b[i] != b[0]) same = 1'b0;
      c = b[0];
      n = int'(c) % 16;
      if (!same)                              rsp = 8'hEE;
      else if (c == 8'hF0)                    rsp = 8'hF0;
      else if (c == 8'hC0) begin rom_m[k] = 8'h00; rsp = 8'hC0; end
      else if (c == 8'hD0)                    rsp = rom_m[k];
      else if (c / 16 == 8'hA && n < NCH) begin rom_m[k] = rom_m[k] | 8'(1 << n);  rsp = c; end
      else if (c / 16 == 8'hB && n < NCH) begin rom_m[k] = rom_m[k] & ~8'(1 << n); rsp = c; end
      else                                    rsp = 8'hEF;
   endtask

   task automatic send_byte(input int k, input logic [7:0] b, input int gap);
      drv_ready[k] = 1'b1;
      drv_data[k]  = b;
      @(posedge clk); #1;
      drv_ready[k] = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
   endtask

   // wait for the response strobe and check it; idle rises at cycle idle_rise
   task automatic await_resp(input int k, input int idle_rise, input int lat, input bit inject,
                             input logic [7:0] exp_txd, input int hold);
      int n    = 0;
      bit seen = 1'b0;
      while (!seen && n < lat + 20) begin
         drv_ready[k] = inject && ($urandom_range(0, 1) == 1);
         drv_data[k]  = 8'($urandom);
         @(posedge clk); #1;
         n++;
         if (n == idle_rise) drv_idle[k] = 1'b1;
         if (hold > 0 && n == hold) check("hold_wait_idle", 32'(obs_st[k]), 32'(ST_WAIT_IDLE));
         if (obs_sig[k]) seen = 1'b1;
      end
      drv_ready[k] = 1'b0;
      drv_idle[k]  = 1'b1;
      check("sig_seen", 32'(seen), 32'd1);
      check("latency", n, lat);
      check("tx_data", 32'(obs_txd[k]), 32'(exp_txd));
      check("rom_en", 32'(obs_rom[k]), 32'(rom_m[k]));
      check("busy_send", 32'(obs_busy[k]), 32'd1);
      // a strobe on the SEND->IDLE cycle must be dropped
      drv_ready[k] = inject;
      drv_data[k]  = 8'($urandom);
      @(posedge clk); #1;
      drv_ready[k] = 1'b0;
      check("sig_single", 32'(obs_sig[k]), 32'd0);
      check("back_idle", 32'(obs_st[k]), 32'(ST_IDLE));
      check("busy_idle", 32'(obs_busy[k]), 32'd0);
      check("tx_data_hold", 32'(obs_txd[k]), 32'(exp_txd));
   endtask

   task automatic send_frame(input int k, input logic [7:0] b0, b1, b2, b3,
                             input int delay, input bit inject);
      logic [7:0] b [4];
      logic [7:0] rsp;
      b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
      check("start_idle", 32'(obs_st[k]), 32'(ST_IDLE));
      model_frame(k, b0, b1, b2, b3, rsp);
      drv_idle[k] = (delay == 0);
      for (int i = 0; i < rep_of(k); i++)
         send_byte(k, b[i], (i == rep_of(k) - 1) ? 0 : int'($urandom_range(0, 2)));
      check("parse_state", 32'(obs_st[k]), 32'(ST_PARSE));
      await_resp(k, delay + 1, delay + 2, inject, rsp, delay);
   endtask

   initial begin
      logic [7:0] c, rsp;
      logic [7:0] fb [4];
      int         k, sig_cnt;

      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         drv_ready[i] = 1'b0; drv_data[i] = 8'h00; drv_idle[i] = 1'b1; rom_m[i] = 8'h00;
      end
      #12;
      for (int i = 0; i < 2; i++) begin
         check("rst_txd", 32'(obs_txd[i]), 32'd0);
         check("rst_sig", 32'(obs_sig[i]), 32'd0);
         check("rst_rom", 32'(obs_rom[i]), 32'd0);
         check("rst_state", 32'(obs_st[i]), 32'(ST_IDLE));
         check("rst_busy", 32'(obs_busy[i]), 32'd0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) begin @(posedge clk); #1; end

      // directed frames
      send_frame(0, 8'hF0, 8'hF0, 8'h00, 8'h00, 0, 1'b0);
      send_frame(0, 8'hA2, 8'hA2, 8'h00, 8'h00, 0, 1'b0);
      send_frame(0, 8'hD0, 8'hD0, 8'h00, 8'h00, 0, 1'b0);
      send_frame(0, 8'hA1, 8'hA7, 8'h00, 8'h00, 0, 1'b0);
      send_frame(0, 8'hA5, 8'hA5, 8'h00, 8'h00, 0, 1'b0);
      send_frame(1, 8'hA1, 8'hA1, 8'hA1, 8'h00, 0, 1'b0);
      send_frame(1, 8'hC0, 8'hC0, 8'hC0, 8'h00, 20, 1'b1);

      // randomized frames with random idle delay and stray bytes
      for (int it = 0; it < 40; it++) begin
         k = int'($urandom_range(0, 1));
         case ($urandom_range(0, 5))
            0:       c = 8'hF0;
            1:       c = 8'hA0 + 8'($urandom_range(0, 7));
            2:       c = 8'hB0 + 8'($urandom_range(0, 7));
            3:       c = 8'hC0;
            4:       c = 8'hD0;
            default: c = 8'($urandom);
         endcase
         for (int i = 0; i < 4; i++) fb[i] = c;
         if ($urandom_range(0, 4) == 0)
            fb[$urandom_range(0, rep_of(k) - 1)] = c ^ 8'(1 << $urandom_range(0, 7));
         send_frame(k, fb[0], fb[1], fb[2], fb[3], int'($urandom_range(0, 4)),
                    1'($urandom_range(0, 1)));
      end

      // single byte followed by silence
`ifdef UART_CMD_TIMEOUT_EN
      send_byte(0, 8'hB0, 0);
      await_resp(0, 0, TO + 2, 1'b0, 8'hED, 0);
`else
      send_byte(0, 8'hB0, 0);
      sig_cnt = 0;
      repeat (3 * TO) begin
         @(posedge clk); #1;
         if (obs_sig[0]) sig_cnt++;
      end
      check("no_timeout_sig", sig_cnt, 0);
      check("collect_wait", 32'(obs_st[0]), 32'(ST_COLLECT));
      model_frame(0, 8'hB0, 8'hB0, 8'h00, 8'h00, rsp);
      send_byte(0, 8'hB0, 0);
      await_resp(0, 1, 2, 1'b0, rsp, 0);
`endif

      // reset while a response is pending in WAIT_IDLE
      drv_idle[0] = 1'b0;
      model_frame(0, 8'hA3, 8'hA3, 8'h00, 8'h00, rsp);
      send_byte(0, 8'hA3, 1);
      send_byte(0, 8'hA3, 0);
      repeat (3) begin @(posedge clk); #1; end
      check("pre_rst_wait", 32'(obs_st[0]), 32'(ST_WAIT_IDLE));
      check("pre_rst_rom", 32'(obs_rom[0]), 32'(rom_m[0]));
      #2 rst_n = 1'b0;
      #1;
      check("arst_txd", 32'(obs_txd[0]), 32'd0);
      check("arst_sig", 32'(obs_sig[0]), 32'd0);
      check("arst_rom", 32'(obs_rom[0]), 32'd0);
      check("arst_rom1", 32'(obs_rom[1]), 32'd0);
      check("arst_state", 32'(obs_st[0]), 32'(ST_IDLE));
      check("arst_busy", 32'(obs_busy[0]), 32'd0);
      rom_m[0] = 8'h00;
      rom_m[1] = 8'h00;
      @(posedge clk); #1;
      rst_n       = 1'b1;
      drv_idle[0] = 1'b1;
      sig_cnt     = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (obs_sig[0]) sig_cnt++;
      end
      check("no_sig_after_rst", sig_cnt, 0);
      send_frame(0, 8'hF0, 8'hF0, 8'h00, 8'h00, 0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
